// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET from commit,
// drives the CSR file's four implicit read/write slots and issues a PC redirect.
module trap_sequencer #(
    parameter logic [1:0]  RESET_MODE = 2'b11,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         exc_valid,
    input  logic [4:0]   exc_cause,
    input  logic [31:0]  exc_pc,
    input  logic [31:0]  exc_tval,
    input  logic         mret_req,
    input  logic         int_boundary,
    input  logic [31:0]  int_pc,
    input  logic         irq_ext,
    input  logic         irq_timer,
    input  logic         irq_sw,
    input  logic [127:0] impl_csr,
    output logic [47:0]  impl_addrs_r,
    output logic [3:0]   impl_read_enable,
    output logic [47:0]  impl_addrs_w,
    output logic [3:0]   impl_write_enable,
    output logic [127:0] impl_write_data,
    output logic         ready,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    output logic [1:0]   mode
);
    localparam int unsigned XLEN = 32;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [1:0]  M_MODE      = 2'b11;
    localparam logic [47:0] IDLE_RADDR  = {CSR_MIP, CSR_MIE, CSR_MTVEC, CSR_MSTATUS};

    typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} state_t;
    state_t state, next_state;

    logic [1:0]      mode_q, mode_n, mpp_q, mpp_n;
    logic [XLEN-1:0] target_q, target_n, redirect_pc_q, redirect_pc_n;
    logic            redir_q, redir_n, ready_q;
    logic [3:0]      re_q, re_n, we_q, we_n;
    logic [47:0]     ra_q, ra_n, wa_q, wa_n;
    logic [127:0]    wd_q, wd_n;

    logic [XLEN-1:0] mstatus, mtvec, mie;
    logic [2:0]      pend;
    logic            int_take;
    logic            acc_trap, acc_mret, acc_int;
    logic [4:0]      acc_code;
    logic [XLEN-1:0] acc_epc, acc_tval, trap_mstatus, mret_mstatus, base, trap_target;
    logic            unused_bits;

    assign mstatus     = impl_csr[31:0];
    assign mtvec       = impl_csr[63:32];
    assign mie         = impl_csr[95:64];
    assign unused_bits = ^{impl_csr[127:96], mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

    assign pend     = {irq_ext & mie[11], irq_timer & mie[7], irq_sw & mie[3]};
    assign int_take = (|pend) && int_boundary && (mstatus[3] || mode_q != M_MODE);

    // Request arbitration in IDLE: exception > interrupt > MRET (illegal MRET becomes cause 2)
    always_comb begin
        acc_trap = 1'b0;
        acc_mret = 1'b0;
        acc_int  = 1'b0;
        acc_code = '0;
        acc_epc  = '0;
        acc_tval = '0;
        if (exc_valid) begin
            acc_trap = 1'b1;
            acc_code = exc_cause;
            acc_epc  = exc_pc;
            acc_tval = exc_tval;
        end else if (int_take) begin
            acc_trap = 1'b1;
            acc_int  = 1'b1;
            acc_code = pend[2] ? 5'd11 : (pend[1] ? 5'd7 : 5'd3);
            acc_epc  = int_pc;
        end else if (mret_req) begin
            if (mode_q != M_MODE) begin
                acc_trap = 1'b1;
                acc_code = 5'd2;
                acc_epc  = exc_pc;
            end else begin
                acc_mret = 1'b1;
            end
        end
    end

    // mstatus images for trap entry and MRET, plus trap vector target
    always_comb begin
        trap_mstatus         = mstatus;
        trap_mstatus[7]      = mstatus[3];
        trap_mstatus[3]      = 1'b0;
        trap_mstatus[12:11]  = mode_q;
        mret_mstatus         = mstatus;
        mret_mstatus[3]      = mstatus[7];
        mret_mstatus[7]      = 1'b1;
        mret_mstatus[12:11]  = 2'b00;
        base                 = {mtvec[31:2], 2'b00};
        trap_target          = base;
        if (mtvec[1:0] == 2'b01 && acc_int)
            trap_target = base + XLEN'(VEC_STRIDE) * {27'd0, acc_code};
    end

    always_comb begin
        next_state    = state;
        mode_n        = mode_q;
        mpp_n         = mpp_q;
        target_n      = target_q;
        redirect_pc_n = redirect_pc_q;
        redir_n       = 1'b0;
        re_n          = '0;
        ra_n          = '0;
        we_n          = '0;
        wa_n          = '0;
        wd_n          = '0;
        case (state)
            IDLE: begin
                if (acc_trap) begin
                    next_state = TRAP;
                    target_n   = trap_target;
                    we_n       = 4'hF;
                    wa_n       = {CSR_MTVAL, CSR_MCAUSE, CSR_MEPC, CSR_MSTATUS};
                    wd_n       = {acc_tval, acc_int, 26'b0, acc_code, acc_epc, trap_mstatus};
                end else if (acc_mret) begin
                    next_state = MRET;
                    mpp_n      = mstatus[12:11];
                    we_n       = 4'b0001;
                    wa_n       = {36'b0, CSR_MSTATUS};
                    wd_n       = {96'b0, mret_mstatus};
                    re_n       = 4'b0010;
                    ra_n       = {24'b0, CSR_MEPC, 12'b0};
                end
            end
            TRAP: begin
                next_state    = REDIR;
                mode_n        = M_MODE;
                redir_n       = 1'b1;
                redirect_pc_n = target_q;
            end
            MRET: begin
                next_state    = REDIR;
                mode_n        = (mpp_q == 2'b10) ? 2'b00 : mpp_q;
                redir_n       = 1'b1;
                target_n      = impl_csr[63:32];
                redirect_pc_n = impl_csr[63:32];
            end
            REDIR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (next_state == IDLE) begin
            re_n = 4'hF;
            ra_n = IDLE_RADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mode_q        <= RESET_MODE;
            mpp_q         <= '0;
            target_q      <= '0;
            redirect_pc_q <= '0;
            redir_q       <= 1'b0;
            ready_q       <= 1'b1;
            re_q          <= 4'hF;
            ra_q          <= IDLE_RADDR;
            we_q          <= '0;
            wa_q          <= '0;
            wd_q          <= '0;
        end else begin
            state         <= next_state;
            mode_q        <= mode_n;
            mpp_q         <= mpp_n;
            target_q      <= target_n;
            redirect_pc_q <= redirect_pc_n;
            redir_q       <= redir_n;
            ready_q       <= (next_state == IDLE);
            re_q          <= re_n;
            ra_q          <= ra_n;
            we_q          <= we_n;
            wa_q          <= wa_n;
            wd_q          <= wd_n;
        end
    end

    // Reset kills a write or redirect already presented in the current cycle
    assign impl_write_enable = we_q & {4{~reset}};
    assign redirect_valid    = redir_q & ~reset;
    assign impl_addrs_r      = ra_q;
    assign impl_read_enable  = re_q;
    assign impl_addrs_w      = wa_q;
    assign impl_write_data   = wd_q;
    assign ready             = ready_q;
    assign redirect_pc       = redirect_pc_q;
    assign mode              = mode_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exceptions, vectored interrupts, priority,
// MRET, reset mid-sequence and back-to-back exceptions.
module tb_trap_sequencer;
    logic         clk = 1'b0;
    logic         reset;
    logic         exc_valid;
    logic [4:0]   exc_cause;
    logic [31:0]  exc_pc, exc_tval;
    logic         mret_req, int_boundary;
    logic [31:0]  int_pc;
    logic         irq_ext, irq_timer, irq_sw;
    logic [127:0] impl_csr;
    logic [47:0]  impl_addrs_r, impl_addrs_w;
    logic [3:0]   impl_read_enable, impl_write_enable;
    logic [127:0] impl_write_data;
    logic         ready, redirect_valid;
    logic [31:0]  redirect_pc;
    logic [1:0]   mode;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] wd0, wd1, wd2, wd3;
    assign wd0 = impl_write_data[31:0];
    assign wd1 = impl_write_data[63:32];
    assign wd2 = impl_write_data[95:64];
    assign wd3 = impl_write_data[127:96];

    trap_sequencer dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_req(mret_req), .int_boundary(int_boundary), .int_pc(int_pc),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .impl_csr(impl_csr),
        .impl_addrs_r(impl_addrs_r), .impl_read_enable(impl_read_enable),
        .impl_addrs_w(impl_addrs_w), .impl_write_enable(impl_write_enable),
        .impl_write_data(impl_write_data),
        .ready(ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_csr(input logic [31:0] ms, input logic [31:0] tv,
                           input logic [31:0] ie, input logic [31:0] ip);
        impl_csr = {ip, ie, tv, ms};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got %0h exp 1", ready); else pass_cnt++;
        total_cnt++; if (mode !== 2'b11) $display("FAIL reset_mode got %0h exp 3", mode); else pass_cnt++;
        total_cnt++; if (impl_write_enable !== 4'h0) $display("FAIL reset_we got %0h exp 0", impl_write_enable); else pass_cnt++;
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv got %0h exp 0", redirect_valid); else pass_cnt++;
        total_cnt++; if (redirect_pc !== 32'h0) $display("FAIL reset_rpc got %0h exp 0", redirect_pc); else pass_cnt++;
        total_cnt++; if (impl_read_enable !== 4'hF) $display("FAIL reset_re got %0h exp f", impl_read_enable); else pass_cnt++;
        total_cnt++; if (impl_addrs_r !== 48'h344_304_305_300) $display("FAIL reset_raddr got %0h exp 344304305300", impl_addrs_r); else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_exception();
        set_csr(32'h8, 32'h100, 32'h0, 32'h0);
        exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
        total_cnt++; if (ready !== 1'b1) $display("FAIL exc_ready_pre got %0h exp 1", ready); else pass_cnt++;
        step();
        exc_valid = 1'b0;
        total_cnt++; if (impl_write_enable !== 4'hF) $display("FAIL exc_we got %0h exp f", impl_write_enable); else pass_cnt++;
        total_cnt++; if (impl_addrs_w !== 48'h343_342_341_300) $display("FAIL exc_waddr got %0h exp 343342341300", impl_addrs_w); else pass_cnt++;
        total_cnt++; if (wd0 !== 32'h1880) $display("FAIL exc_mstatus got %0h exp 1880", wd0); else pass_cnt++;
        total_cnt++; if (wd1 !== 32'h40) $display("FAIL exc_mepc got %0h exp 40", wd1); else pass_cnt++;
        total_cnt++; if (wd2 !== 32'h2) $display("FAIL exc_mcause got %0h exp 2", wd2); else pass_cnt++;
        total_cnt++; if (wd3 !== 32'hDEAD) $display("FAIL exc_mtval got %0h exp dead", wd3); else pass_cnt++;
        total_cnt++; if (ready !== 1'b0) $display("FAIL exc_ready_trap got %0h exp 0", ready); else pass_cnt++;
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL exc_rv_early got %0h exp 0", redirect_valid); else pass_cnt++;
        total_cnt++; if (impl_read_enable !== 4'h0) $display("FAIL exc_re_trap got %0h exp 0", impl_read_enable); else pass_cnt++;
        step();
        total_cnt++; if (redirect_valid !== 1'b1) $display("FAIL exc_rv got %0h exp 1", redirect_valid); else pass_cnt++;
        total_cnt++; if (redirect_pc !== 32'h100) $display("FAIL exc_rpc got %0h exp 100", redirect_pc); else pass_cnt++;
        total_cnt++; if (impl_write_enable !== 4'h0) $display("FAIL exc_we_redir got %0h exp 0", impl_write_enable); else pass_cnt++;
        step();
        total_cnt++; if (ready !== 1'b1) $display("FAIL exc_ready_post got %0h exp 1", ready); else pass_cnt++;
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL exc_rv_post got %0h exp 0", redirect_valid); else pass_cnt++;
    endtask

    task automatic test_vectored_int();
        set_csr(32'h8, 32'h201, 32'h80, 32'h80);
        irq_timer = 1'b1; int_boundary = 1'b1; int_pc = 32'h80;
        step();
        irq_timer = 1'b0;
        total_cnt++; if (wd2 !== 32'h8000_0007) $display("FAIL vint_mcause got %0h exp 80000007", wd2); else pass_cnt++;
        total_cnt++; if (wd1 !== 32'h80) $display("FAIL vint_mepc got %0h exp 80", wd1); else pass_cnt++;
        total_cnt++; if (wd3 !== 32'h0) $display("FAIL vint_mtval got %0h exp 0", wd3); else pass_cnt++;
        total_cnt++; if (wd0 !== 32'h1880) $display("FAIL vint_mstatus got %0h exp 1880", wd0); else pass_cnt++;
        step();
        total_cnt++; if (redirect_pc !== 32'h21C) $display("FAIL vint_rpc got %0h exp 21c", redirect_pc); else pass_cnt++;
        total_cnt++; if (redirect_valid !== 1'b1) $display("FAIL vint_rv got %0h exp 1", redirect_valid); else pass_cnt++;
        step();
    endtask

    task automatic test_priority_mask();
        set_csr(32'h8, 32'h201, 32'h880, 32'h880);
        irq_ext = 1'b1; irq_timer = 1'b1; int_boundary = 1'b1; int_pc = 32'h90;
        exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h44; exc_tval = 32'h11;
        step();
        exc_valid = 1'b0;
        total_cnt++; if (wd2 !== 32'h5) $display("FAIL prio_mcause got %0h exp 5", wd2); else pass_cnt++;
        total_cnt++; if (wd1 !== 32'h44) $display("FAIL prio_mepc got %0h exp 44", wd1); else pass_cnt++;
        step();
        total_cnt++; if (redirect_pc !== 32'h200) $display("FAIL prio_rpc got %0h exp 200", redirect_pc); else pass_cnt++;
        step();
        total_cnt++; if (ready !== 1'b1) $display("FAIL prio_ready got %0h exp 1", ready); else pass_cnt++;
        step();
        total_cnt++; if (wd2 !== 32'h8000_000B) $display("FAIL ext_mcause got %0h exp 8000000b", wd2); else pass_cnt++;
        total_cnt++; if (wd1 !== 32'h90) $display("FAIL ext_mepc got %0h exp 90", wd1); else pass_cnt++;
        set_csr(32'h0, 32'h201, 32'h880, 32'h880);
        step();
        total_cnt++; if (redirect_pc !== 32'h22C) $display("FAIL ext_rpc got %0h exp 22c", redirect_pc); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (ready !== 1'b1) $display("FAIL mask_ready[%0d] got %0h exp 1", i, ready); else pass_cnt++;
            total_cnt++; if (impl_write_enable !== 4'h0) $display("FAIL mask_we[%0d] got %0h exp 0", i, impl_write_enable); else pass_cnt++;
        end
        irq_ext = 1'b0; irq_timer = 1'b0;
    endtask

    task automatic test_mret();
        set_csr(32'h80, 32'h300, 32'h0, 32'h0);
        mret_req = 1'b1;
        step();
        mret_req = 1'b0;
        total_cnt++; if (impl_write_enable !== 4'b0001) $display("FAIL mret_we got %0h exp 1", impl_write_enable); else pass_cnt++;
        total_cnt++; if (impl_addrs_w[11:0] !== 12'h300) $display("FAIL mret_waddr got %0h exp 300", impl_addrs_w[11:0]); else pass_cnt++;
        total_cnt++; if (wd0 !== 32'h88) $display("FAIL mret_mstatus got %0h exp 88", wd0); else pass_cnt++;
        total_cnt++; if (impl_read_enable !== 4'b0010) $display("FAIL mret_re got %0h exp 2", impl_read_enable); else pass_cnt++;
        total_cnt++; if (impl_addrs_r[23:12] !== 12'h341) $display("FAIL mret_raddr got %0h exp 341", impl_addrs_r[23:12]); else pass_cnt++;
        step();
        total_cnt++; if (redirect_pc !== 32'h300) $display("FAIL mret_rpc got %0h exp 300", redirect_pc); else pass_cnt++;
        total_cnt++; if (mode !== 2'b00) $display("FAIL mret_mode got %0h exp 0", mode); else pass_cnt++;
        step();
        mret_req = 1'b1; exc_pc = 32'h50;
        step();
        mret_req = 1'b0;
        total_cnt++; if (impl_write_enable !== 4'hF) $display("FAIL umret_we got %0h exp f", impl_write_enable); else pass_cnt++;
        total_cnt++; if (wd2 !== 32'h2) $display("FAIL umret_mcause got %0h exp 2", wd2); else pass_cnt++;
        total_cnt++; if (wd1 !== 32'h50) $display("FAIL umret_mepc got %0h exp 50", wd1); else pass_cnt++;
        total_cnt++; if (wd0 !== 32'h0) $display("FAIL umret_mstatus got %0h exp 0", wd0); else pass_cnt++;
        step();
        total_cnt++; if (mode !== 2'b11) $display("FAIL umret_mode got %0h exp 3", mode); else pass_cnt++;
        total_cnt++; if (redirect_pc !== 32'h300) $display("FAIL umret_rpc got %0h exp 300", redirect_pc); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid();
        set_csr(32'h8, 32'h100, 32'h0, 32'h0);
        exc_valid = 1'b1; exc_cause = 5'd3; exc_pc = 32'h60; exc_tval = 32'h1;
        step();
        exc_valid = 1'b0;
        reset = 1'b1;
        #1;
        total_cnt++; if (impl_write_enable !== 4'h0) $display("FAIL rmid_we got %0h exp 0", impl_write_enable); else pass_cnt++;
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL rmid_rv got %0h exp 0", redirect_valid); else pass_cnt++;
        step();
        reset = 1'b0;
        total_cnt++; if (ready !== 1'b1) $display("FAIL rmid_ready got %0h exp 1", ready); else pass_cnt++;
        total_cnt++; if (mode !== 2'b11) $display("FAIL rmid_mode got %0h exp 3", mode); else pass_cnt++;
        step();
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL rmid_rv_late got %0h exp 0", redirect_valid); else pass_cnt++;
        total_cnt++; if (impl_write_enable !== 4'h0) $display("FAIL rmid_we_late got %0h exp 0", impl_write_enable); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        set_csr(32'h8, 32'h100, 32'h0, 32'h0);
        exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h70; exc_tval = 32'h0;
        for (int i = 0; i < 12; i++) begin
            total_cnt++; if (ready !== ((i % 3) == 0)) $display("FAIL b2b_ready[%0d] got %0h exp %0h", i, ready, (i % 3) == 0); else pass_cnt++;
            total_cnt++; if (redirect_valid !== ((i % 3) == 2)) $display("FAIL b2b_rv[%0d] got %0h exp %0h", i, redirect_valid, (i % 3) == 2); else pass_cnt++;
            if (redirect_valid === 1'b1) pulses++;
            step();
        end
        exc_valid = 1'b0;
        total_cnt++; if (ready !== 1'b1) $display("FAIL b2b_ready_end got %0h exp 1", ready); else pass_cnt++;
        step();
        total_cnt++; if (ready !== 1'b1) $display("FAIL b2b_idle got %0h exp 1", ready); else pass_cnt++;
        total_cnt++; if (pulses != 4) $display("FAIL b2b_pulses got %0d exp 4", pulses); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        mret_req = 1'b0; int_boundary = 1'b0; int_pc = '0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0; impl_csr = '0;
        test_reset();
        test_exception();
        test_vectored_int();
        test_priority_mask();
        test_mret();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
